// File: rtl/cpu_memory.sv
// Memory stage: issues p3 loads/stores on the data bus, freezes the pipeline while
// a transaction is outstanding, and returns aligned load data or a fault to p4.
package cpu_memory_pkg;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_LDB  = 6'h10;
    localparam logic [5:0] OP_LDBU = 6'h11;
    localparam logic [5:0] OP_LDH  = 6'h12;
    localparam logic [5:0] OP_LDHU = 6'h13;
    localparam logic [5:0] OP_LDW  = 6'h14;
    localparam logic [5:0] OP_STB  = 6'h18;
    localparam logic [5:0] OP_STH  = 6'h19;
    localparam logic [5:0] OP_STW  = 6'h1A;
endpackage

module cpu_memory
    import cpu_memory_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        p3_valid,
    input  logic [5:0]  p3_op,
    input  logic [31:0] p3_addr,
    input  logic [31:0] p3_wdata,
    output logic        dbus_request,
    output logic        dbus_write,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_wstrb,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        mem_stall,
    output logic [31:0] p4_load_data,
    output logic        p4_load_valid,
    output logic        p4_misaligned,
    output logic        p4_bus_error,
    output logic [31:0] p4_fault_addr
);

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

    // size: 0 = byte, 1 = half, 2 = word
    typedef struct packed {
        logic       is_mem;
        logic       is_store;
        logic [1:0] size;
        logic       uns;
    } op_info_t;

    localparam bit           TO_EN    = (TIMEOUT_CYCLES != 32'd0);
    localparam int           CW       = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 32'd1);

    function automatic op_info_t decode_op(input logic [5:0] op);
        op_info_t r;
        r = '0;
        case (op)
            OP_LDB:  r = '{1'b1, 1'b0, 2'd0, 1'b0};
            OP_LDBU: r = '{1'b1, 1'b0, 2'd0, 1'b1};
            OP_LDH:  r = '{1'b1, 1'b0, 2'd1, 1'b0};
            OP_LDHU: r = '{1'b1, 1'b0, 2'd1, 1'b1};
            OP_LDW:  r = '{1'b1, 1'b0, 2'd2, 1'b0};
            OP_STB:  r = '{1'b1, 1'b1, 2'd0, 1'b0};
            OP_STH:  r = '{1'b1, 1'b1, 2'd1, 1'b0};
            OP_STW:  r = '{1'b1, 1'b1, 2'd2, 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] s;
        case (size)
            2'd0:    s = 4'b0001 << lo;
            2'd1:    s = 4'b0011 << {lo[1], 1'b0};
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            2'd0:    w = {4{d[7:0]}};
            2'd1:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_align(input logic [1:0] size, input logic uns,
                                               input logic [1:0] lo, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (size)
            2'd0:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'd1:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    state_t        state_r, state_s;
    logic          req_r, req_s;
    logic          write_r, write_s;
    logic [31:0]   addr_r, addr_s;
    logic [3:0]    wstrb_r, wstrb_s;
    logic [31:0]   wdata_r, wdata_s;
    logic [1:0]    size_r, size_s;
    logic          uns_r, uns_s;
    logic [1:0]    lo_r, lo_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [31:0]   ldata_r, ldata_s;
    logic          lv_r, lv_s;
    logic          mis_r, mis_s;
    logic          berr_r, berr_s;
    logic [31:0]   fault_r, fault_s;
    op_info_t      info_s;
    logic          aligned_s;
    logic          issue_ok_s;

    // Decode the p3 operation and its alignment requirement
    always_comb begin
        info_s = decode_op(p3_op);
        case (info_s.size)
            2'd1:    aligned_s = ~p3_addr[0];
            2'd2:    aligned_s = (p3_addr[1:0] == 2'b00);
            default: aligned_s = 1'b1;
        endcase
    end

    // Next-state logic: completion/timeout of the current access, then a possible new launch
    always_comb begin
        state_s    = state_r;
        req_s      = req_r;
        write_s    = write_r;
        addr_s     = addr_r;
        wstrb_s    = wstrb_r;
        wdata_s    = wdata_r;
        size_s     = size_r;
        uns_s      = uns_r;
        lo_s       = lo_r;
        cnt_s      = cnt_r;
        ldata_s    = ldata_r;
        fault_s    = fault_r;
        lv_s       = 1'b0;
        mis_s      = 1'b0;
        berr_s     = 1'b0;
        issue_ok_s = 1'b0;

        case (state_r)
            IDLE: issue_ok_s = 1'b1;
            WAIT: begin
                if (dbus_ack) begin
                    // Ack beats timeout; the pipeline advances this cycle so a new op may launch
                    state_s    = IDLE;
                    req_s      = 1'b0;
                    cnt_s      = '0;
                    issue_ok_s = 1'b1;
                    if (!write_r) begin
                        ldata_s = load_align(size_r, uns_r, lo_r, dbus_rdata);
                        lv_s    = 1'b1;
                    end else begin
                        lv_s    = 1'b0;
                    end
                end else if (TO_EN && (cnt_r == CNT_LAST)) begin
                    state_s = IDLE;
                    req_s   = 1'b0;
                    cnt_s   = '0;
                    berr_s  = 1'b1;
                    fault_s = addr_r;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                req_s   = 1'b0;
            end
        endcase

        if (issue_ok_s && p3_valid && info_s.is_mem && !stall) begin
            if (aligned_s) begin
                state_s = WAIT;
                req_s   = 1'b1;
                write_s = info_s.is_store;
                addr_s  = {p3_addr[31:2], 2'b00};
                wstrb_s = info_s.is_store ? store_strb(info_s.size, p3_addr[1:0]) : 4'b0000;
                wdata_s = info_s.is_store ? store_data(info_s.size, p3_wdata) : 32'd0;
                size_s  = info_s.size;
                uns_s   = info_s.uns;
                lo_s    = p3_addr[1:0];
                cnt_s   = '0;
            end else begin
                mis_s   = 1'b1;
                fault_s = p3_addr;
            end
        end else begin
            mis_s = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            req_r   <= 1'b0;
            write_r <= 1'b0;
            addr_r  <= 32'd0;
            wstrb_r <= 4'd0;
            wdata_r <= 32'd0;
            size_r  <= 2'd0;
            uns_r   <= 1'b0;
            lo_r    <= 2'd0;
            cnt_r   <= '0;
            ldata_r <= 32'd0;
            lv_r    <= 1'b0;
            mis_r   <= 1'b0;
            berr_r  <= 1'b0;
            fault_r <= 32'd0;
        end else begin
            state_r <= state_s;
            req_r   <= req_s;
            write_r <= write_s;
            addr_r  <= addr_s;
            wstrb_r <= wstrb_s;
            wdata_r <= wdata_s;
            size_r  <= size_s;
            uns_r   <= uns_s;
            lo_r    <= lo_s;
            cnt_r   <= cnt_s;
            ldata_r <= ldata_s;
            lv_r    <= lv_s;
            mis_r   <= mis_s;
            berr_r  <= berr_s;
            fault_r <= fault_s;
        end
    end

    assign dbus_request  = req_r;
    assign dbus_write    = write_r;
    assign dbus_addr     = addr_r;
    assign dbus_wstrb    = wstrb_r;
    assign dbus_wdata    = wdata_r;
    assign p4_load_data  = ldata_r;
    assign p4_load_valid = lv_r;
    assign p4_misaligned = mis_r;
    assign p4_bus_error  = berr_r;
    assign p4_fault_addr = fault_r;
    assign mem_stall     = (state_r == WAIT) && !dbus_ack;

endmodule

// File: tb/tb_cpu_memory.sv
// Directed bench for cpu_memory (TIMEOUT_CYCLES = 4) with hand-computed expectations.
module tb_cpu_memory;
    import cpu_memory_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        p3_valid;
    logic [5:0]  p3_op;
    logic [31:0] p3_addr;
    logic [31:0] p3_wdata;
    logic        dbus_request;
    logic        dbus_write;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_wstrb;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic        mem_stall;
    logic [31:0] p4_load_data;
    logic        p4_load_valid;
    logic        p4_misaligned;
    logic        p4_bus_error;
    logic [31:0] p4_fault_addr;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_memory #(.TIMEOUT_CYCLES(32'd4)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .p3_valid(p3_valid), .p3_op(p3_op), .p3_addr(p3_addr), .p3_wdata(p3_wdata),
        .dbus_request(dbus_request), .dbus_write(dbus_write), .dbus_addr(dbus_addr),
        .dbus_wstrb(dbus_wstrb), .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack),
        .dbus_rdata(dbus_rdata), .mem_stall(mem_stall), .p4_load_data(p4_load_data),
        .p4_load_valid(p4_load_valid), .p4_misaligned(p4_misaligned),
        .p4_bus_error(p4_bus_error), .p4_fault_addr(p4_fault_addr)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input string tag, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        p3_valid = 1'b1; p3_op = op; p3_addr = addr; p3_wdata = 32'd0;
        step();
        p3_valid = 1'b0;
        check({tag, "_req"}, dbus_request, 32'd1);
        check({tag, "_addr"}, dbus_addr, {addr[31:2], 2'b00});
        check({tag, "_strb"}, dbus_wstrb, 32'd0);
        dbus_ack = 1'b1; dbus_rdata = rdata;
        #1;
        check({tag, "_stall_ack"}, mem_stall, 32'd0);
        step();
        dbus_ack = 1'b0;
        check({tag, "_valid"}, p4_load_valid, 32'd1);
        check({tag, "_data"}, p4_load_data, exp);
        check({tag, "_req_drop"}, dbus_request, 32'd0);
        step();
        check({tag, "_pulse"}, p4_load_valid, 32'd0);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; p3_valid = 1'b0; p3_op = 6'd0;
        p3_addr = 32'd0; p3_wdata = 32'd0; dbus_ack = 1'b0; dbus_rdata = 32'd0;
        #12;
        check("rst_req", dbus_request, 32'd0);
        check("rst_addr", dbus_addr, 32'd0);
        check("rst_ldata", p4_load_data, 32'd0);
        check("rst_stall", mem_stall, 32'd0);
        reset = 1'b1;
        step();

        // Byte/half loads: lane select and extension
        do_load("ldb", OP_LDB, 32'h0000_1003, 32'h8012_3456, 32'hFFFF_FF80);
        do_load("ldbu", OP_LDBU, 32'h0000_1003, 32'h8012_3456, 32'h0000_0080);
        do_load("ldh", OP_LDH, 32'h0000_100A, 32'h8001_7FFF, 32'hFFFF_8001);
        do_load("ldhu", OP_LDHU, 32'h0000_1008, 32'h8001_F00F, 32'h0000_F00F);

        // Halfword store in upper lanes
        p3_valid = 1'b1; p3_op = OP_STH; p3_addr = 32'h0000_2002; p3_wdata = 32'h1234_ABCD;
        step();
        p3_valid = 1'b0;
        check("sth_req", dbus_request, 32'd1);
        check("sth_write", dbus_write, 32'd1);
        check("sth_addr", dbus_addr, 32'h0000_2000);
        check("sth_strb", dbus_wstrb, 32'h0000_000C);
        check("sth_wdata", dbus_wdata, 32'hABCD_ABCD);
        dbus_ack = 1'b1;
        step();
        dbus_ack = 1'b0;
        check("sth_no_lv", p4_load_valid, 32'd0);
        check("sth_req_drop", dbus_request, 32'd0);

        // Byte store lane 1
        p3_valid = 1'b1; p3_op = OP_STB; p3_addr = 32'h0000_2101; p3_wdata = 32'h0000_00A5;
        step();
        p3_valid = 1'b0;
        check("stb_strb", dbus_wstrb, 32'h0000_0002);
        check("stb_wdata", dbus_wdata, 32'hA5A5_A5A5);
        dbus_ack = 1'b1;
        step();
        dbus_ack = 1'b0;

        // Misaligned word load
        p3_valid = 1'b1; p3_op = OP_LDW; p3_addr = 32'h0000_3001;
        #1;
        check("mis_stall_pre", mem_stall, 32'd0);
        step();
        p3_valid = 1'b0;
        check("mis_req", dbus_request, 32'd0);
        check("mis_flag", p4_misaligned, 32'd1);
        check("mis_fault", p4_fault_addr, 32'h0000_3001);
        check("mis_stall", mem_stall, 32'd0);
        step();
        check("mis_pulse", p4_misaligned, 32'd0);

        // Launch held off by external stall, then three wait states
        p3_valid = 1'b1; p3_op = OP_LDW; p3_addr = 32'h0000_4000; stall = 1'b1;
        step();
        check("stall_hold1", dbus_request, 32'd0);
        step();
        check("stall_hold2", dbus_request, 32'd0);
        stall = 1'b0;
        step();
        p3_valid = 1'b0;
        check("ldw_req", dbus_request, 32'd1);
        for (int i = 0; i < 3; i++) begin
            stall = (i == 1);
            #1;
            check("ldw_wait_stall", mem_stall, 32'd1);
            check("ldw_wait_req", dbus_request, 32'd1);
            check("ldw_wait_addr", dbus_addr, 32'h0000_4000);
            step();
        end
        stall = 1'b0;
        dbus_ack = 1'b1; dbus_rdata = 32'hCAFE_F00D;
        #1;
        check("ldw_ack_stall", mem_stall, 32'd0);
        step();
        dbus_ack = 1'b0;
        check("ldw_valid", p4_load_valid, 32'd1);
        check("ldw_data", p4_load_data, 32'hCAFE_F00D);

        // Ack while idle is ignored
        dbus_ack = 1'b1;
        step();
        dbus_ack = 1'b0;
        check("idle_ack_lv", p4_load_valid, 32'd0);
        check("idle_ack_req", dbus_request, 32'd0);

        // Timeout after four unacknowledged wait cycles
        p3_valid = 1'b1; p3_op = OP_LDW; p3_addr = 32'h0000_5004;
        step();
        p3_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to_req", dbus_request, 32'd1);
            check("to_berr_early", p4_bus_error, 32'd0);
            step();
        end
        check("to_req_drop", dbus_request, 32'd0);
        check("to_berr", p4_bus_error, 32'd1);
        check("to_fault", p4_fault_addr, 32'h0000_5004);
        check("to_stall", mem_stall, 32'd0);
        step();
        check("to_pulse", p4_bus_error, 32'd0);

        // Reset in the middle of a wait; later ack ignored
        p3_valid = 1'b1; p3_op = OP_STW; p3_addr = 32'h0000_6000; p3_wdata = 32'h5555_AAAA;
        step();
        p3_valid = 1'b0;
        check("rmw_req", dbus_request, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rmw_req_drop", dbus_request, 32'd0);
        check("rmw_stall", mem_stall, 32'd0);
        check("rmw_ldata", p4_load_data, 32'd0);
        #2;
        reset = 1'b1;
        dbus_ack = 1'b1;
        step();
        dbus_ack = 1'b0;
        check("rmw_ack_lv", p4_load_valid, 32'd0);
        check("rmw_ack_req", dbus_request, 32'd0);

        // Non-memory op
        p3_valid = 1'b1; p3_op = OP_ADD; p3_addr = 32'h0000_0010;
        #1;
        check("add_stall", mem_stall, 32'd0);
        step();
        check("add_req", dbus_request, 32'd0);
        step();
        check("add_req2", dbus_request, 32'd0);
        p3_valid = 1'b0;

        // Back-to-back STW then LDW launched on the store's ack edge
        p3_valid = 1'b1; p3_op = OP_STW; p3_addr = 32'h0000_7000; p3_wdata = 32'h1122_3344;
        step();
        check("b2b_st_strb", dbus_wstrb, 32'h0000_000F);
        check("b2b_st_wdata", dbus_wdata, 32'h1122_3344);
        p3_op = OP_LDW; p3_addr = 32'h0000_7008;
        dbus_ack = 1'b1;
        #1;
        check("b2b_ack_stall", mem_stall, 32'd0);
        step();
        dbus_ack = 1'b0; p3_valid = 1'b0;
        check("b2b_ld_req", dbus_request, 32'd1);
        check("b2b_ld_write", dbus_write, 32'd0);
        check("b2b_ld_addr", dbus_addr, 32'h0000_7008);
        check("b2b_st_no_lv", p4_load_valid, 32'd0);
        dbus_ack = 1'b1; dbus_rdata = 32'hDEAD_BEEF;
        step();
        dbus_ack = 1'b0;
        check("b2b_ld_valid", p4_load_valid, 32'd1);
        check("b2b_ld_data", p4_load_data, 32'hDEAD_BEEF);
        check("b2b_req_drop", dbus_request, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cpu_memory.md
Name: cpu_memory

Overview:
Pipeline stage directly downstream of the execute stage. It takes load/store operations leaving p3 and issues them on the CPU data bus. It freezes the pipeline while a bus transaction is outstanding, then aligns and extends load data into p4. Misaligned accesses and bus timeouts are flagged to the trap logic instead of being issued or completed.

Parameters:
TIMEOUT_CYCLES, 0, cycles in WAIT before abort with bus error; 0 disables the timeout counter.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
stall  input  1  pipeline stall from sources other than this block
p3_valid  input  1  p3 holds a valid instruction
p3_op  input  6  operation code (`OP_* from cpu.vh)
p3_addr  input  32  effective address of the memory op
p3_wdata  input  32  store data (unaligned, low bits significant)
dbus_request  output  1  bus request, held until ack
dbus_write  output  1  1=store, 0=load
dbus_addr  output  32  word-aligned address ({addr[31:2],2'b00})
dbus_wstrb  output  4  byte-lane write strobes
dbus_wdata  output  32  lane-replicated store data
dbus_ack  input  1  single-cycle completion
dbus_rdata  input  32  load data, valid with ack
mem_stall  output  1  freeze whole pipeline
p4_load_data  output  32  aligned/extended load result
p4_load_valid  output  1  one-cycle pulse, load result written
p4_misaligned  output  1  one-cycle pulse, misaligned access rejected
p4_bus_error  output  1  one-cycle pulse, timeout abort
p4_fault_addr  output  32  address of faulting access

Behaviour:
- Reset (async, active-low): state IDLE. dbus_request, dbus_write, p4_load_valid, p4_misaligned and p4_bus_error are 0. dbus_addr, dbus_wstrb, dbus_wdata, p4_load_data and p4_fault_addr are 0. Timeout counter is 0.
- Memory ops: `OP_LDB, LDBU, LDH, LDHU, LDW, STB, STH, STW. All other ops are ignored: no request, no stall.
- Alignment: H ops need addr[0]=0; W ops need addr[1:0]=0. Byte ops are always aligned.
- States: IDLE, WAIT.
- IDLE to WAIT: on a clock edge with p3_valid & mem op & aligned & !stall. The edge registers dbus_addr, dbus_write, dbus_wstrb, dbus_wdata and the load type, and sets dbus_request=1.
- IDLE, misaligned: on the same launch condition with a misaligned address, state stays IDLE. p4_misaligned=1 and p4_fault_addr=p3_addr for one cycle. No bus request.
- While stall=1 in IDLE, nothing launches.
- Stores: strobe B = 0001<<addr[1:0], H = 0011<<{addr[1],1'b0}, W = 1111. wdata B = {4{d[7:0]}}, H = {2{d[15:0]}}, W = d.
- Loads: select the lane by addr[1:0] (B) or addr[1] (H). LDB/LDH sign-extend; LDBU/LDHU zero-extend.
- WAIT: dbus_request stays 1 and all bus outputs are stable until dbus_ack.
  - mem_stall = (state==WAIT) & !dbus_ack, combinational, so the pipeline advances in the ack cycle.
  - On the ack edge: state IDLE, dbus_request=0. For loads, p4_load_data is updated and p4_load_valid=1 for one cycle.
  - The stall input is ignored in WAIT.
- Earliest ack: the first cycle dbus_request is high. Best-case stall is 0 cycles; each wait-state cycle adds 1 stall cycle.
- Back-to-back memory ops: a new launch may occur on the ack edge. In that case dbus_request stays 1 with the new address.
- Timeout (TIMEOUT_CYCLES>0): the counter increments each WAIT cycle without ack. On reaching TIMEOUT_CYCLES: state IDLE, dbus_request=0, p4_bus_error=1 for one cycle, p4_fault_addr=dbus_addr. An ack in the same cycle wins over the timeout.
- Reset mid-WAIT: request drops immediately. Any ack arriving afterwards is ignored (IDLE ignores dbus_ack).
- dbus_ack in IDLE: ignored.

Test Plan:
- LDB at 0x00001003, ack next cycle with rdata 0x80123456 -> dbus_addr 0x00001000, dbus_wstrb 0000, p4_load_data 0xFFFFFF80, p4_load_valid 1 cycle. Repeat as LDBU -> 0x00000080.
- STH addr 0x00002002 wdata 0x1234ABCD -> dbus_write 1, dbus_wstrb 1100, dbus_wdata 0xABCDABCD, no p4_load_valid.
- LDW at 0x00003001 -> no dbus_request, p4_misaligned 1 cycle, p4_fault_addr 0x00003001, mem_stall never high.
- LDW at 0x00004000, ack delayed 3 cycles -> mem_stall high exactly 3 cycles, request stable throughout, then data captured. Also check stall=1 in IDLE delays launch.
- TIMEOUT_CYCLES=4, never ack -> p4_bus_error after 4 WAIT cycles, request drops. Separately, assert reset mid-WAIT -> request 0 immediately, later ack ignored.
- Non-memory ops (`OP_ADD) with p3_valid=1 -> no request, no stall. Back-to-back STW/LDW -> second request launched on first ack edge.
